// File: rtl/ring_digit_scanner.sv
// Digit-select scanner for a 4-digit multiplexed 7-segment display driven by a one-hot ring phase.
// Inserts blanking dead-time on phase changes, flags non-one-hot phases, holds a BCD shadow value.
module ring_digit_scanner #(
   parameter int BLANK_CYC = 2,
   parameter int LZB       = 1
) (
   input  logic        c,
   input  logic        r,
   input  logic [3:0]  phase,
   input  logic        val_load,
   input  logic [15:0] val_in,
   output logic        val_ack,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        fault,
   output logic [1:0]  state_dbg
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      DRIVE = 2'd2,
      FAULT = 2'd3
   } state_t;

   localparam int CW = (BLANK_CYC > 2) ? $clog2(BLANK_CYC) : 1;
   localparam logic [CW-1:0] CNT_LOAD = (BLANK_CYC > 0) ? CW'(BLANK_CYC - 1) : '0;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [3:0]    an_n;
   logic [6:0]    seg_n;
   logic          fault_n;
   logic [15:0]   shadow;
   logic [3:0]    phase_q;
   logic          onehot, changed, commit;
   logic          enter, to_fault;
   logic [1:0]    idx;
   logic [3:0]    nib;
   logic [15:0]   upper;
   logic [6:0]    drive_seg;

   function automatic logic [6:0] decode(input logic [3:0] d);
      case (d)
         4'd0:    decode = 7'h40;
         4'd1:    decode = 7'h79;
         4'd2:    decode = 7'h24;
         4'd3:    decode = 7'h30;
         4'd4:    decode = 7'h19;
         4'd5:    decode = 7'h12;
         4'd6:    decode = 7'h02;
         4'd7:    decode = 7'h78;
         4'd8:    decode = 7'h00;
         4'd9:    decode = 7'h10;
         default: decode = 7'h3F;
      endcase
   endfunction

   assign onehot    = $onehot(phase);
   assign changed   = (phase != phase_q);
   assign state_dbg = state;

   // Handshake: val_load is a level request; a commit happens on an edge where the scanner is
   // not driving and no ack is in flight, and val_ack is high for exactly the following cycle.
   assign commit = val_load && !val_ack && (state != DRIVE);

   always_comb begin
      idx = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (phase[i]) idx = 2'(i);
      end
      nib       = shadow[{idx, 2'b00} +: 4];
      upper     = shadow >> {idx, 2'b00};
      drive_seg = (LZB != 0 && idx != 2'd0 && upper == 16'h0000) ? 7'h7F : decode(nib);
   end

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      an_n     = an;
      seg_n    = seg;
      fault_n  = 1'b0;
      enter    = 1'b0;
      to_fault = 1'b0;
      case (state)
         IDLE: begin
            an_n  = 4'hF;
            seg_n = 7'h7F;
            if (onehot) enter = 1'b1;
         end
         BLANK: begin
            if (!onehot) to_fault = 1'b1;
            else if (changed) enter = 1'b1;
            else if (cnt == '0) begin
               state_n = DRIVE;
               an_n    = ~phase;
               seg_n   = drive_seg;
            end else begin
               cnt_n = cnt - 1'b1;
               an_n  = 4'hF;
               seg_n = 7'h7F;
            end
         end
         DRIVE: begin
            // Outputs are held while the phase is steady, so the shown digit never changes mid-drive.
            if (!onehot) to_fault = 1'b1;
            else if (changed) enter = 1'b1;
         end
         FAULT: begin
            if (!onehot) to_fault = 1'b1;
            else enter = 1'b1;
         end
         default: begin
            state_n = IDLE;
            an_n    = 4'hF;
            seg_n   = 7'h7F;
         end
      endcase

      if (to_fault) begin
         state_n = FAULT;
         an_n    = 4'hF;
         seg_n   = 7'h7F;
         fault_n = 1'b1;
      end else if (enter) begin
         if (BLANK_CYC == 0) begin
            state_n = DRIVE;
            an_n    = ~phase;
            seg_n   = drive_seg;
         end else begin
            state_n = BLANK;
            cnt_n   = CNT_LOAD;
            an_n    = 4'hF;
            seg_n   = 7'h7F;
         end
      end
   end

   always_ff @(posedge c or negedge r) begin
      if (!r) begin
         state   <= IDLE;
         cnt     <= '0;
         an      <= 4'hF;
         seg     <= 7'h7F;
         fault   <= 1'b0;
         val_ack <= 1'b0;
         shadow  <= 16'h0000;
         phase_q <= 4'h0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         an      <= an_n;
         seg     <= seg_n;
         fault   <= fault_n;
         val_ack <= commit;
         phase_q <= phase;
         if (commit) shadow <= val_in;
      end
   end

endmodule

// File: tb/tb_ring_digit_scanner.sv
// Bench for ring_digit_scanner: directed scenarios plus randomized phase/load traffic checked
// against a timeline model (edges since last phase event, snapshot of the value at display start).
module tb_ring_digit_scanner;

   localparam int BLANK_CYC_TB = 2;
   localparam int LZB_TB       = 1;

   logic        c = 1'b0;
   logic        r = 1'b0;
   logic [3:0]  phase = 4'h0;
   logic        val_load = 1'b0;
   logic [15:0] val_in = 16'h0000;
   logic        val_ack;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        fault;
   logic [1:0]  state_dbg;

   int checks = 0;
   int failures = 0;

   ring_digit_scanner #(.BLANK_CYC(BLANK_CYC_TB), .LZB(LZB_TB)) dut (
      .c(c), .r(r), .phase(phase), .val_load(val_load), .val_in(val_in),
      .val_ack(val_ack), .an(an), .seg(seg), .fault(fault), .state_dbg(state_dbg)
   );

   always #5 c = ~c;

   // reference model
   logic [15:0] exp_q[$];
   logic        running, in_fault, m_valid, m_ack, valid, commit;
   int          since;
   logic [15:0] m_shadow, snap;
   logic [3:0]  p_prev, exp_an;
   logic [6:0]  exp_seg;
   logic        exp_fault;

   function automatic logic [6:0] seg_of(input logic [15:0] v, input int i);
      logic [3:0] n;
      n = 4'((v >> (4 * i)) & 16'hF);
      if (LZB_TB != 0 && i > 0 && (v >> (4 * i)) == 16'h0) return 7'h7F;
      case (n)
         4'd0: return 7'h40;
         4'd1: return 7'h79;
         4'd2: return 7'h24;
         4'd3: return 7'h30;
         4'd4: return 7'h19;
         4'd5: return 7'h12;
         4'd6: return 7'h02;
         4'd7: return 7'h78;
         4'd8: return 7'h00;
         4'd9: return 7'h10;
         default: return 7'h3F;
      endcase
   endfunction

   function automatic int pos_of(input logic [3:0] p);
      for (int i = 0; i < 4; i++) if (p[i]) return i;
      return 0;
   endfunction

   always @(posedge c or negedge r) begin
      if (!r) begin
         running = 0; in_fault = 0; since = 0; m_valid = 0; m_ack = 0;
         m_shadow = 16'h0; snap = 16'h0; p_prev = 4'h0;
         exp_an = 4'hF; exp_seg = 7'h7F; exp_fault = 0;
      end else begin
         commit = val_load && !m_ack && !m_valid;
         if (!running) begin
            if ($countones(phase) == 1) begin running = 1; since = 0; end
         end else if ($countones(phase) != 1) begin
            in_fault = 1;
         end else if (in_fault || phase != p_prev) begin
            in_fault = 0; since = 0;
         end else if (since < 1000) begin
            since++;
         end
         exp_fault = running && ($countones(phase) != 1);
         valid = running && !exp_fault && since >= BLANK_CYC_TB;
         if (valid && since == BLANK_CYC_TB) snap = m_shadow;
         exp_an  = valid ? ~phase : 4'hF;
         exp_seg = valid ? seg_of(snap, pos_of(phase)) : 7'h7F;
         m_ack = commit;
         if (commit) begin
            m_shadow = val_in;
            exp_q.push_back(val_in);
         end
         m_valid = valid;
         p_prev = phase;
      end
   end

   task automatic tick();
      @(posedge c);
      @(negedge c);
   endtask

   task automatic go_drive(input logic [3:0] p);
      phase = p;
      repeat (3) tick();
   endtask

   task automatic load_val(input logic [15:0] v, output logic ok);
      ok = 0;
      phase = 4'h0;
      val_in = v;
      val_load = 1;
      for (int i = 0; i < 10 && !ok; i++) begin
         tick();
         if (val_ack) ok = 1;
      end
      val_load = 0;
   endtask

   task automatic test_reset();
      r = 0; phase = 4'h0; val_load = 0;
      repeat (2) @(negedge c);
      checks++; if (an !== 4'hF) begin failures++; $display("FAIL reset_an got=%h want=f", an); end
      checks++; if (seg !== 7'h7F) begin failures++; $display("FAIL reset_seg got=%h want=7f", seg); end
      checks++; if (val_ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b want=0", val_ack); end
      checks++; if (fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%b want=0", fault); end
      r = 1;
      tick();
      checks++; if (an !== 4'hF || fault !== 1'b0) begin failures++; $display("FAIL idle_zero got an=%h fault=%b want an=f fault=0", an, fault); end
      phase = 4'b0011;
      tick();
      checks++; if (fault !== 1'b0 || an !== 4'hF) begin failures++; $display("FAIL idle_multi got an=%h fault=%b want an=f fault=0", an, fault); end
      go_drive(4'b0001);
      checks++; if (an !== 4'b1110) begin failures++; $display("FAIL pre_reset_drive got=%b want=1110", an); end
      #1 r = 0;
      #1;
      checks++; if (an !== 4'hF || seg !== 7'h7F || val_ack !== 1'b0) begin
         failures++; $display("FAIL async_reset got an=%h seg=%h ack=%b want an=f seg=7f ack=0", an, seg, val_ack);
      end
      @(negedge c);
      r = 1;
   endtask

   task automatic test_load_scan();
      int acks = 0;
      go_drive(4'b0001);
      phase = 4'b0010; val_in = 16'h1234; val_load = 1;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (val_ack) begin acks++; val_load = 0; end
         checks++; if ({an, seg, fault, val_ack} !== {exp_an, exp_seg, exp_fault, m_ack}) begin
            failures++; $display("FAIL load_scan_cyc%0d got an=%b seg=%h f=%b ack=%b want an=%b seg=%h f=%b ack=%b",
                                 i, an, seg, fault, val_ack, exp_an, exp_seg, exp_fault, m_ack);
         end
      end
      val_load = 0;
      checks++; if (acks != 1) begin failures++; $display("FAIL load_ack_count got=%0d want=1", acks); end
      checks++; if (an !== 4'b1101 || seg !== 7'h30) begin failures++; $display("FAIL load_digit1 got an=%b seg=%h want an=1101 seg=30", an, seg); end
      go_drive(4'b1000);
      checks++; if (an !== 4'b0111 || seg !== 7'h79) begin failures++; $display("FAIL load_digit3 got an=%b seg=%h want an=0111 seg=79", an, seg); end
   endtask

   task automatic test_blank_timing();
      phase = 4'b0001;
      tick();
      checks++; if (an !== 4'hF) begin failures++; $display("FAIL blank_k got=%b want=1111", an); end
      tick();
      checks++; if (an !== 4'hF) begin failures++; $display("FAIL blank_k1 got=%b want=1111", an); end
      tick();
      checks++; if (an !== 4'b1110) begin failures++; $display("FAIL blank_k2 got=%b want=1110", an); end
      phase = 4'b0010;
      tick();
      phase = 4'b0100;
      tick();
      tick();
      checks++; if (an !== 4'hF) begin failures++; $display("FAIL reblank_k2 got=%b want=1111", an); end
      tick();
      checks++; if (an !== 4'b1011) begin failures++; $display("FAIL reblank_k3 got=%b want=1011", an); end
   endtask

   task automatic test_fault();
      go_drive(4'b0001);
      phase = 4'b0011;
      tick();
      checks++; if (fault !== 1'b1 || an !== 4'hF || seg !== 7'h7F) begin
         failures++; $display("FAIL fault_enter got f=%b an=%b seg=%h want f=1 an=1111 seg=7f", fault, an, seg);
      end
      phase = 4'b0100;
      tick();
      checks++; if (fault !== 1'b0 || an !== 4'hF) begin failures++; $display("FAIL fault_exit got f=%b an=%b want f=0 an=1111", fault, an); end
      tick();
      tick();
      checks++; if (an !== 4'b1011 || fault !== 1'b0) begin failures++; $display("FAIL fault_resume got f=%b an=%b want f=0 an=1011", fault, an); end
   endtask

   task automatic test_lzb();
      logic [15:0] vals[3] = '{16'h0007, 16'h0000, 16'h00A0};
      logic [6:0]  want[3][4] = '{'{7'h78, 7'h7F, 7'h7F, 7'h7F},
                                  '{7'h40, 7'h7F, 7'h7F, 7'h7F},
                                  '{7'h40, 7'h3F, 7'h7F, 7'h7F}};
      logic ok;
      for (int v = 0; v < 3; v++) begin
         load_val(vals[v], ok);
         checks++; if (!ok) begin failures++; $display("FAIL lzb_load%0d no ack within 10 cycles", v); end
         for (int i = 3; i >= 0; i--) begin
            go_drive(4'b0001 << i);
            checks++; if (an !== ~(4'b0001 << i) || seg !== want[v][i] || seg !== exp_seg) begin
               failures++; $display("FAIL lzb_v%0d_d%0d got an=%b seg=%h want an=%b seg=%h model=%h",
                                    v, i, an, seg, ~(4'b0001 << i), want[v][i], exp_seg);
            end
         end
      end
   endtask

   task automatic test_random();
      int k;
      logic [15:0] got_v;
      exp_q.delete();
      for (int n = 0; n < 600; n++) begin
         if (val_ack) begin
            if ($urandom_range(0, 3) != 0) val_load = 0;
         end else if (!val_load && $urandom_range(0, 5) == 0) begin
            val_in = 16'($urandom);
            val_load = 1;
         end
         k = $urandom_range(0, 15);
         if (k >= 9 && k < 14) phase = 4'b0001 << $urandom_range(0, 3);
         else if (k == 14) phase = 4'($urandom_range(0, 15));
         else if (k == 15 && $urandom_range(0, 3) == 0) phase = 4'h0;
         tick();
         checks++; if ({an, seg, fault, val_ack} !== {exp_an, exp_seg, exp_fault, m_ack}) begin
            failures++; $display("FAIL rand_cyc%0d got an=%b seg=%h f=%b ack=%b want an=%b seg=%h f=%b ack=%b",
                                 n, an, seg, fault, val_ack, exp_an, exp_seg, exp_fault, m_ack);
         end
         if (val_ack) begin
            checks++;
            if (exp_q.size() == 0) begin failures++; $display("FAIL rand_ack_unexpected cyc%0d got ack=1 want none pending", n); end
            else got_v = exp_q.pop_front();
         end
      end
      val_load = 0;
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rand_ack_missing got pending=%0d want 0", exp_q.size()); end
   endtask

   initial begin
      test_reset();
      test_load_scan();
      test_blank_timing();
      test_fault();
      test_lzb();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
